// File: rtl/matrix_stream_pkg.sv
// Shared types and constants for the matrix-packet stream generator.
package matrix_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HDR0,
        ST_PAY0,
        ST_HDR1,
        ST_PAY1,
        ST_DONE
    } state_t;

    localparam logic [1:0] FILL_MODE_CONST = 2'd0;
    localparam logic [1:0] FILL_MODE_INC   = 2'd1;
    localparam logic [1:0] FILL_MODE_LFSR  = 2'd2;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/stream_lfsr.sv
// 32-bit Galois LFSR supplying pseudo-random payload words.
module stream_lfsr (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);
    import matrix_stream_pkg::*;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 32'h0000_0001;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/matrix_stream_gen.sv
// AXI4-Stream generator emitting header+payload matrix packets with delay, repeat and stop control.
module matrix_stream_gen
    import matrix_stream_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 10,
    parameter int                DELAY_W     = 20,
    parameter int                START_DELAY = 20000,
    parameter logic [DATA_W-1:0] HDR0        = DATA_W'(32'hFF00_0240),
    parameter int                LEN0        = 144,
    parameter logic [DATA_W-1:0] HDR1        = DATA_W'(32'hFF00_0120),
    parameter int                LEN1        = 72,
    parameter logic [DATA_W-1:0] FILL_CONST  = DATA_W'(1),
    parameter logic [31:0]       LFSR_SEED   = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        fill_mode,
    input  logic [7:0]        repeat_count,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0]   LEN0_C     = CNT_W'(LEN0);
    localparam logic [CNT_W-1:0]   LEN1_C     = CNT_W'(LEN1);
    localparam logic [CNT_W-1:0]   ONE_C      = CNT_W'(1);
    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic [CNT_W-1:0]    idx_q, idx_d, pay_idx;
    logic [7:0]          seq_q, seq_d, seq_next;
    logic [7:0]          rep_q, rep_d;
    logic [1:0]          mode_q, mode_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic                stop_q, stop_d;
    logic                busy_q, done_q;
    logic                lfsr_load, lfsr_adv;
    logic [31:0]         lfsr_q;
    logic [DATA_W-1:0]   pay_word;
    logic                hs, end_seq;

    stream_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    assign hs       = tvalid_q & m_axis_tready;
    assign seq_next = seq_q + 8'd1;
    assign pay_idx  = (state_q == ST_PAY0 || state_q == ST_PAY1) ? idx_q + 1'b1 : ONE_C;

    // Word for the payload beat about to be loaded; the LFSR advances as that beat is loaded
    always_comb begin
        pay_word = FILL_CONST;
        if (mode_q == FILL_MODE_INC) begin
            pay_word = DATA_W'(pay_idx);
        end else if (mode_q == FILL_MODE_LFSR) begin
            pay_word = DATA_W'(lfsr_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        rep_d     = rep_q;
        mode_d    = mode_q;
        delay_d   = delay_q;
        stop_d    = stop_q | (stop & (state_q != ST_IDLE));
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        end_seq   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start) begin
                    mode_d    = fill_mode;
                    rep_d     = repeat_count;
                    seq_d     = '0;
                    delay_d   = '0;
                    lfsr_load = 1'b1;
                    state_d   = (START_DELAY == 0) ? ST_HDR0 : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (stop) begin
                    state_d = ST_DONE;
                end else if (m_axis_tready) begin
                    if (delay_q == DELAY_LAST) state_d = ST_HDR0;
                    else                       delay_d = delay_q + 1'b1;
                end
            end
            ST_HDR0: begin
                // Entered from IDLE/DELAY with the bus empty: present the header first
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    tdata_d  = HDR0;
                    tlast_d  = 1'b0;
                end else if (hs) begin
                    state_d  = ST_PAY0;
                    idx_d    = ONE_C;
                    tdata_d  = pay_word;
                    tlast_d  = (LEN0_C == ONE_C);
                    lfsr_adv = 1'b1;
                end
            end
            ST_PAY0: begin
                if (hs) begin
                    if (idx_q == LEN0_C) begin
                        if (LEN1_C != '0) begin
                            state_d = ST_HDR1;
                            tdata_d = HDR1;
                            tlast_d = 1'b0;
                        end else begin
                            end_seq = 1'b1;
                        end
                    end else begin
                        idx_d    = pay_idx;
                        tdata_d  = pay_word;
                        tlast_d  = (pay_idx == LEN0_C);
                        lfsr_adv = 1'b1;
                    end
                end
            end
            ST_HDR1: begin
                if (hs) begin
                    state_d  = ST_PAY1;
                    idx_d    = ONE_C;
                    tdata_d  = pay_word;
                    tlast_d  = (LEN1_C == ONE_C);
                    lfsr_adv = 1'b1;
                end
            end
            ST_PAY1: begin
                if (hs) begin
                    if (idx_q == LEN1_C) begin
                        end_seq = 1'b1;
                    end else begin
                        idx_d    = pay_idx;
                        tdata_d  = pay_word;
                        tlast_d  = (pay_idx == LEN1_C);
                        lfsr_adv = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Sequence boundary: either finish the run or roll straight into the next header
        if (end_seq) begin
            seq_d = seq_next;
            if (stop_q || stop || (rep_q != 8'd0 && seq_next == rep_q)) begin
                state_d  = ST_DONE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = '0;
            end else begin
                state_d = ST_HDR0;
                tdata_d = HDR0;
                tlast_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            idx_q    <= '0;
            seq_q    <= '0;
            rep_q    <= '0;
            mode_q   <= FILL_MODE_CONST;
            delay_q  <= '0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            rep_q    <= rep_d;
            mode_q   <= mode_d;
            delay_q  <= delay_d;
            stop_q   <= stop_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_matrix_stream_gen.sv
// Directed self-checking bench for matrix_stream_gen using three differently parameterised instances.
module tb_matrix_stream_gen;

    localparam logic [31:0] H0 = 32'hFF00_0240;
    localparam logic [31:0] H1 = 32'hFF00_0120;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: delay 4, LEN0 3, LEN1 2
    logic        a_start = 1'b0, a_stop = 1'b0, a_tready = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [7:0]  a_rep = 8'd0;
    logic [31:0] a_tdata;
    logic        a_tvalid, a_tlast, a_busy, a_done;

    // Instance B: no delay, LEN0 5, no packet 1
    logic        b_start = 1'b0, b_stop = 1'b0, b_tready = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic [7:0]  b_rep = 8'd0;
    logic [31:0] b_tdata;
    logic        b_tvalid, b_tlast, b_busy, b_done;

    // Instance C: no delay, LEN0 2, no packet 1
    logic        c_start = 1'b0, c_stop = 1'b0, c_tready = 1'b0;
    logic [1:0]  c_mode = 2'd0;
    logic [7:0]  c_rep = 8'd0;
    logic [31:0] c_tdata;
    logic        c_tvalid, c_tlast, c_busy, c_done;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_stream_gen #(.START_DELAY(4), .LEN0(3), .LEN1(2)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .start(a_start), .stop(a_stop), .fill_mode(a_mode),
        .repeat_count(a_rep), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(a_tready), .m_axis_tlast(a_tlast), .busy(a_busy), .done(a_done)
    );

    matrix_stream_gen #(.START_DELAY(0), .LEN0(5), .LEN1(0)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .start(b_start), .stop(b_stop), .fill_mode(b_mode),
        .repeat_count(b_rep), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .busy(b_busy), .done(b_done)
    );

    matrix_stream_gen #(.START_DELAY(0), .LEN0(2), .LEN1(0)) u_dut_c (
        .clk(clk), .reset_n(rst_n), .start(c_start), .stop(c_stop), .fill_mode(c_mode),
        .repeat_count(c_rep), .m_axis_tdata(c_tdata), .m_axis_tvalid(c_tvalid),
        .m_axis_tready(c_tready), .m_axis_tlast(c_tlast), .busy(c_busy), .done(c_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({a_tvalid, a_tlast, a_busy, a_done} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_a_flags: got %b expected 0000", {a_tvalid, a_tlast, a_busy, a_done});
        end
        n_checks++;
        if ({a_tdata, b_tdata, c_tdata} !== 96'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_tdata: got %h %h %h expected all 0", a_tdata, b_tdata, c_tdata);
        end
        n_checks++;
        if ({b_tvalid, b_busy, c_tvalid, c_busy, b_done, c_done} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_bc_flags: got %b expected 000000",
                     {b_tvalid, b_busy, c_tvalid, c_busy, b_done, c_done});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({a_busy, a_tvalid} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL idle_after_release: got %b expected 00", {a_busy, a_tvalid});
        end
    endtask

    task automatic test_const_packet();
        logic        ev, el, edn;
        logic [31:0] ew;
        a_mode = 2'd0; a_rep = 8'd1; a_tready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_checks++;
        if ({a_busy, a_tvalid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL const_start_busy: got %b expected 10", {a_busy, a_tvalid});
        end
        for (int j = 1; j <= 13; j++) begin
            tick();
            ev  = (j >= 5 && j <= 11);
            el  = (j == 8 || j == 11);
            edn = (j == 12);
            case (j)
                5:       ew = H0;
                9:       ew = H1;
                default: ew = 32'h1;
            endcase
            n_checks++;
            if ({a_tvalid, a_tlast, a_done} !== {ev, el, edn}) begin
                n_fail++;
                $display("[TB] FAIL const_ctrl cyc %0d: got v/l/d %b expected %b", j,
                         {a_tvalid, a_tlast, a_done}, {ev, el, edn});
            end
            if (ev) begin
                n_checks++;
                if (a_tdata !== ew) begin
                    n_fail++;
                    $display("[TB] FAIL const_data cyc %0d: got %h expected %h", j, a_tdata, ew);
                end
            end
        end
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL const_busy_end: got %b expected 0", a_busy);
        end
    endtask

    task automatic test_delay_gating();
        a_mode = 2'd0; a_rep = 8'd1; a_tready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            a_tready = (j % 2 == 1);
            tick();
            n_checks++;
            if (a_tvalid !== (j == 8)) begin
                n_fail++;
                $display("[TB] FAIL delay_gate cyc %0d: got tvalid %b expected %b", j, a_tvalid, (j == 8));
            end
        end
        n_checks++;
        if (a_tdata !== H0) begin
            n_fail++;
            $display("[TB] FAIL delay_hdr: got %h expected %h", a_tdata, H0);
        end
        a_tready = 1'b1;
        for (int j = 0; j < 20 && a_done !== 1'b1; j++) tick();
        n_checks++;
        if (a_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL delay_done_timeout: got done %b expected 1", a_done);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] pat = 16'b0101_1100_1011_0100;
        logic [31:0] hd, ew;
        logic        hl, held;
        int          beats = 0;
        b_mode = 2'd1; b_rep = 8'd1; b_tready = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n_checks++;
        if ({b_busy, b_tvalid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL nodelay_edge_k: got busy/valid %b expected 10", {b_busy, b_tvalid});
        end
        tick();
        n_checks++;
        if ({b_tvalid, b_tlast, b_tdata} !== {2'b10, H0}) begin
            n_fail++;
            $display("[TB] FAIL nodelay_hdr: got v/l %b data %h expected 10 %h", {b_tvalid, b_tlast}, b_tdata, H0);
        end
        held = 1'b0; hd = '0; hl = 1'b0;
        for (int cyc = 0; cyc < 80 && beats < 6; cyc++) begin
            b_tready = pat[cyc % 16];
            held = 1'b0;
            if (b_tvalid && b_tready) begin
                ew = (beats == 0) ? H0 : beats;
                n_checks++;
                if ({b_tdata, b_tlast} !== {ew, (beats == 5)}) begin
                    n_fail++;
                    $display("[TB] FAIL bp_beat %0d: got %h last %b expected %h last %b", beats,
                             b_tdata, b_tlast, ew, (beats == 5));
                end
                beats++;
            end else if (b_tvalid) begin
                held = 1'b1; hd = b_tdata; hl = b_tlast;
            end
            tick();
            if (held) begin
                n_checks++;
                if ({b_tvalid, b_tlast, b_tdata} !== {1'b1, hl, hd}) begin
                    n_fail++;
                    $display("[TB] FAIL bp_stall_hold: got v %b l %b d %h expected 1 %b %h",
                             b_tvalid, b_tlast, b_tdata, hl, hd);
                end
            end
        end
        n_checks++;
        if (beats != 6) begin
            n_fail++;
            $display("[TB] FAIL bp_beat_count: got %0d expected 6", beats);
        end
        b_tready = 1'b1;
        for (int j = 0; j < 10 && b_done !== 1'b1; j++) tick();
        n_checks++;
        if ({b_done, b_tvalid} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL bp_done: got done/valid %b expected 10", {b_done, b_tvalid});
        end
        tick();
    endtask

    task automatic test_lfsr();
        logic        ev, el, edn;
        logic [31:0] ew;
        c_mode = 2'd2; c_rep = 8'd3; c_tready = 1'b1; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            ev  = (j <= 9);
            el  = (j == 3 || j == 6 || j == 9);
            edn = (j == 10);
            case (j)
                2:       ew = 32'h0000_0001;
                3:       ew = 32'h8020_0003;
                5:       ew = 32'hC030_0002;
                6:       ew = 32'h6018_0001;
                8:       ew = 32'hB02C_0003;
                9:       ew = 32'hD836_0002;
                default: ew = H0;
            endcase
            n_checks++;
            if ({c_tvalid, c_tlast, c_done} !== {ev, el, edn}) begin
                n_fail++;
                $display("[TB] FAIL lfsr_ctrl cyc %0d: got v/l/d %b expected %b", j,
                         {c_tvalid, c_tlast, c_done}, {ev, el, edn});
            end
            if (ev) begin
                n_checks++;
                if (c_tdata !== ew) begin
                    n_fail++;
                    $display("[TB] FAIL lfsr_data cyc %0d: got %h expected %h", j, c_tdata, ew);
                end
            end
        end
        tick();
    endtask

    task automatic test_stop();
        logic        ev, el, edn;
        logic [31:0] ew;
        a_mode = 2'd1; a_rep = 8'd0; a_tready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int j = 1; j <= 26; j++) begin
            a_stop = (j == 18);
            tick();
            ev  = (j >= 5 && j <= 18);
            el  = (j == 8 || j == 11 || j == 15 || j == 18);
            edn = (j == 19);
            case (j)
                5, 12:          ew = H0;
                9, 16:          ew = H1;
                6, 10, 13, 17:  ew = 32'd1;
                7, 11, 14, 18:  ew = 32'd2;
                default:        ew = 32'd3;
            endcase
            n_checks++;
            if ({a_tvalid, a_tlast, a_done} !== {ev, el, edn}) begin
                n_fail++;
                $display("[TB] FAIL stop_ctrl cyc %0d: got v/l/d %b expected %b", j,
                         {a_tvalid, a_tlast, a_done}, {ev, el, edn});
            end
            if (ev) begin
                n_checks++;
                if (a_tdata !== ew) begin
                    n_fail++;
                    $display("[TB] FAIL stop_data cyc %0d: got %h expected %h", j, a_tdata, ew);
                end
            end
        end
        a_stop = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stop_busy_end: got %b expected 0", a_busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic        ev, el;
        logic [31:0] ew;
        a_mode = 2'd0; a_rep = 8'd1; a_tready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (6) tick();
        n_checks++;
        if ({a_tvalid, a_tdata} !== {1'b1, 32'h1}) begin
            n_fail++;
            $display("[TB] FAIL midpkt_pre: got v %b d %h expected 1 00000001", a_tvalid, a_tdata);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_tvalid, a_tlast, a_busy, a_done, a_tdata} !== {4'b0000, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL midpkt_async_reset: got v/l/b/d %b data %h expected 0000 0",
                     {a_tvalid, a_tlast, a_busy, a_done}, a_tdata);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            ev = (j >= 5);
            el = (j == 8);
            ew = (j == 5) ? H0 : 32'h1;
            n_checks++;
            if ({a_tvalid, a_tlast} !== {ev, el} || (ev && a_tdata !== ew)) begin
                n_fail++;
                $display("[TB] FAIL midpkt_restart cyc %0d: got v/l %b d %h expected %b %h", j,
                         {a_tvalid, a_tlast}, a_tdata, {ev, el}, ew);
            end
        end
        for (int j = 0; j < 10 && a_done !== 1'b1; j++) tick();
        n_checks++;
        if (a_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midpkt_done_timeout: got done %b expected 1", a_done);
        end
        tick();
    endtask

    initial begin
        $display("[TB] matrix_stream_gen directed tests starting");
        test_reset();
        test_const_packet();
        test_delay_gating();
        test_backpressure();
        test_lfsr();
        test_stop();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_stream_gen.md
# matrix_stream_gen

Parametrised AXI4-Stream matrix-packet generator feeding the matrix multiplier's input stream port in hardware test builds. After a start request and a configurable ready-gated start-up delay, it emits an operand-A packet and an optional operand-B packet. Each packet is one header word followed by a payload of constant, incrementing or pseudo-random words. It adds full backpressure compliance, repeat/stop control and payload fill modes.

## Interface
- DATA_W, 32, stream data width (≥ 32)
- CNT_W, 10, payload counter width; LEN0, LEN1 ≤ 2^CNT_W − 1
- DELAY_W, 20, start-up delay counter width
- START_DELAY, 20000, ready-high cycles to wait before first header; 0 = no delay
- HDR0 / LEN0, 32'hFF000240 / 144, packet 0 header word / payload words (LEN0 ≥ 1)
- HDR1 / LEN1, 32'hFF000120 / 72, packet 1 header / payload words; LEN1 = 0 omits packet 1
- FILL_CONST, 1, payload value in constant mode
- LFSR_SEED, 32'h0000_0001, LFSR seed (must be nonzero)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level sampled in IDLE; starts a run
- stop  in  1  requests end of run at the next packet boundary
- fill_mode  in  2  0 constant, 1 incrementing, 2 LFSR, 3 treated as 0; sampled with start
- repeat_count  in  8  (packet 0, packet 1) sequences per run; 0 = until stop; sampled with start
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last payload beat of each packet
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion

## Operation
- FSM states: IDLE, DELAY, HDR0, PAY0, HDR1, PAY1, DONE.
- IDLE + start=1 → DELAY, or HDR0 if START_DELAY = 0. fill_mode and repeat_count are latched. Sequence counter, LFSR and delay counter are cleared or seeded.
- DELAY: delay counter increments only on cycles with m_axis_tready = 1. When it reaches START_DELAY − 1 with tready = 1, the FSM moves to HDR0. tvalid stays 0 throughout.
- HDR0: drives HDR0 with tlast = 0. On handshake (tvalid & tready) → PAY0, payload index = 1.
- PAY0: drives word index 1..LEN0. tlast = 1 at index LEN0. On the last handshake → HDR1 if LEN1 ≠ 0, else end-of-sequence.
- HDR1 and PAY1 behave the same way with HDR1 and LEN1.
- End-of-sequence: increment the sequence counter. Go to DONE if stop has been seen since the last boundary, or if repeat_count ≠ 0 and the count has been reached. Otherwise go to HDR0.
- stop is sticky once asserted in a busy state. It never truncates a packet. stop during DELAY → DONE directly.
- DONE: done = 1 for one cycle, then IDLE.
- Payload word:
  - Constant mode: FILL_CONST.
  - Incrementing mode: the index, zero-extended to DATA_W, restarting at 1 in every packet.
  - LFSR mode: the current LFSR state. The LFSR is a Galois x^32+x^22+x^2+x+1 and advances once per accepted payload beat across packets and sequences. Headers never advance it.
- start while busy is ignored.

## Timing
- Reset values: tdata = 0, tvalid = 0, tlast = 0, busy = 0, done = 0, state IDLE. Reset takes effect asynchronously; release is synchronised to clk in the reset tree, not in this block.
- Reset mid-packet: tvalid drops immediately and the packet is abandoned; no recovery beat is sent.
- All outputs are registered. tvalid, tdata and tlast change only at a rising edge.
- tvalid never depends combinationally on tready. Once tvalid = 1, tdata and tlast hold until the handshake.
- Back-to-back throughput with tready held at 1 is one beat per cycle, including header-to-payload and packet-to-packet transitions; there are no bubbles.
- start sampled at edge k with START_DELAY = 0: tvalid = 1 with HDR0 in the cycle after edge k+1.
- busy = 1 from the cycle after start is accepted through the DONE cycle.

## Structure
- Package matrix_stream_pkg holds:
  - the FSM state enum
  - the fill-mode constants
  - the LFSR tap mask constant
- Sub-module stream_lfsr has ports clk, reset_n, load, seed, advance and q.
- Everything else (FSM, delay, payload and sequence counters, output register) lives in the top level.

## Test plan
- START_DELAY=4, LEN0=3, LEN1=2, constant mode, repeat=1, tready=1 → 4 idle cycles, then FF000240,1,1,1(last),FF000120,1,1(last) on consecutive cycles, then a done pulse.
- Delay gating: tready alternates 1/0 during DELAY with START_DELAY=4 → first header appears after the 4th ready-high cycle, not the 4th cycle.
- Backpressure: random tready (50%) in incrementing mode, LEN0=5 → packet 0 payload is exactly 1..5, tdata/tvalid stable while stalled, tlast only on 5.
- LEN1=0, repeat=3, LFSR mode → three single packets; payload continues the LFSR sequence from seed 1 across packets; headers are not counted.
- repeat=0, assert stop mid-PAY1 → PAY1 completes with tlast, then done; no further HDR0.
- reset_n low mid-PAY0 → tvalid, tlast, busy = 0 immediately; after release, a new start produces a full packet from HDR0.
